// File: rtl/req8_code_fifo.sv
// Captures rising edges on eight async request lines, queues the highest-priority
// pending line as a 3-bit code into a small FIFO, and flags lost events.
module req8_code_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                req,
    input  logic                      clr_ovr,
    input  logic                      out_ready,
    output logic [2:0]                out_code,
    output logic                      out_valid,
    output logic [7:0]                pending,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    sync1_q, sync2_q, sync3_q;
    logic [2:0]    fill_q;
    logic [7:0]    pend_q, pend_d;
    logic [7:0]    ev, gnt_oh;
    logic [2:0]    gnt_code;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [2:0]    mem_q [DEPTH];
    logic [2:0]    head_q, head_d;
    logic          valid_q;
    logic          ovr_q, ovr_d;
    logic          full, push, pop, ovr_ev;

    // fill_q masks edge detection until sync3 holds post-reset samples, so a
    // line held high through reset release never looks like a new event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            fill_q  <= '0;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            fill_q  <= {fill_q[1:0], 1'b1};
        end
    end

    assign ev   = sync2_q & ~sync3_q & {8{fill_q[2]}};
    assign pop  = valid_q & out_ready;
    assign full = (level_q == LW'(DEPTH));
    assign push = (pend_q != 8'd0) && (!full || pop);

    // Priority encoder: later iterations override, so the highest set bit wins.
    always_comb begin
        gnt_code = 3'd0;
        gnt_oh   = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend_q[i]) gnt_code = 3'(i);
        end
        if (push) gnt_oh = 8'b1 << gnt_code;
    end

    always_comb begin
        pend_d   = (pend_q & ~gnt_oh) | ev;
        ovr_ev   = |(ev & pend_q & ~gnt_oh);
        ovr_d    = ovr_ev | (ovr_q & ~clr_ovr);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A push lands on the head slot only when the queue is empty after any pop.
        head_d = (push && (wr_ptr_q == rd_ptr_d)) ? gnt_code : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            pend_q   <= pend_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= (level_d != LW'(0));
            ovr_q    <= ovr_d;
            if (push) mem_q[wr_ptr_q] <= gnt_code;
        end
    end

    assign out_code  = head_q;
    assign out_valid = valid_q;
    assign pending   = pend_q;
    assign level     = level_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_req8_code_fifo.sv
// Directed bench for req8_code_fifo: latency, priority, walk, full, overrun, reset.
module tb_req8_code_fifo;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       clr_ovr;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_valid;
    logic [7:0] pending;
    logic [2:0] level;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    req8_code_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .clr_ovr   (clr_ovr),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_valid (out_valid),
        .pending   (pending),
        .level     (level),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse on the request lines, counted as the first of its edges.
    task automatic pulse(input logic [7:0] v);
        req = v;
        step(1);
        req = 8'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 8'd0; clr_ovr = 1'b0; out_ready = 1'b0;
        step(2);
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_level",   32'(level),     32'd0);
        check("rst_pending", 32'(pending),   32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);
        check("rst_code",    32'(out_code),  32'd0);
        rst = 1'b0;
        step(4);

        // Single request: pending after 3rd edge, valid after 4th, popped on 5th.
        out_ready = 1'b1;
        req = 8'h80;
        step(2);
        check("single_valid_e2", 32'(out_valid), 32'd0);
        step(1);
        check("single_pend_e3",  32'(pending),   32'h80);
        check("single_valid_e3", 32'(out_valid), 32'd0);
        step(1);
        check("single_valid_e4", 32'(out_valid), 32'd1);
        check("single_code_e4",  32'(out_code),  32'd7);
        check("single_level_e4", 32'(level),     32'd1);
        check("single_pend_e4",  32'(pending),   32'h00);
        req = 8'd0;
        step(1);
        check("single_valid_e5", 32'(out_valid), 32'd0);
        check("single_level_e5", 32'(level),     32'd0);
        step(4);
        check("single_fall",     32'(level),     32'd0);

        // Priority: two lines rise together, higher one queued first.
        out_ready = 1'b0;
        pulse(8'h24);
        step(2);
        check("prio_pend",   32'(pending),  32'h24);
        step(1);
        check("prio_lvl1",   32'(level),    32'd1);
        check("prio_code1",  32'(out_code), 32'd5);
        check("prio_pend1",  32'(pending),  32'h04);
        step(1);
        check("prio_lvl2",   32'(level),    32'd2);
        check("prio_pend2",  32'(pending),  32'h00);
        out_ready = 1'b1;
        step(1);
        check("prio_drain2", 32'(out_code), 32'd2);
        check("prio_drlvl",  32'(level),    32'd1);
        step(1);
        check("prio_empty",  32'(out_valid), 32'd0);

        // Walk one-hot from bit 7 to bit 0.
        for (int i = 7; i >= 0; i--) begin
            pulse(8'b1 << i);
            step(3);
            check("walk_valid", 32'(out_valid), 32'd1);
            check("walk_code",  32'(out_code),  32'(i));
            step(2);
        end
        check("walk_overrun", 32'(overrun), 32'd0);
        check("walk_level",   32'(level),   32'd0);

        // Full: six lines, four queued, two lowest remain pending.
        out_ready = 1'b0;
        pulse(8'hFC);
        step(6);
        check("full_level",   32'(level),     32'd4);
        check("full_valid",   32'(out_valid), 32'd1);
        check("full_pending", 32'(pending),   32'h0C);
        out_ready = 1'b1;
        for (int c = 7; c >= 2; c--) begin
            check("full_drain_valid", 32'(out_valid), 32'd1);
            check("full_drain_code",  32'(out_code),  32'(c));
            step(1);
        end
        check("full_end_level", 32'(level),     32'd0);
        check("full_end_pend",  32'(pending),   32'h00);
        check("full_end_valid", 32'(out_valid), 32'd0);
        check("full_overrun",   32'(overrun),   32'd0);

        // Overrun: line 3 twice while the FIFO is full.
        out_ready = 1'b0;
        pulse(8'hF0);
        step(6);
        check("ovr_fill", 32'(level), 32'd4);
        pulse(8'h08);
        step(4);
        check("ovr_pend1", 32'(pending), 32'h08);
        check("ovr_flag1", 32'(overrun), 32'd0);
        pulse(8'h08);
        step(2);
        check("ovr_flag2", 32'(overrun), 32'd1);
        check("ovr_pend2", 32'(pending), 32'h08);
        check("ovr_level", 32'(level),   32'd4);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        check("ovr_clr",      32'(overrun), 32'd0);
        check("ovr_clr_pend", 32'(pending), 32'h08);
        out_ready = 1'b1;
        step(6);
        check("ovr_drain_level", 32'(level),   32'd0);
        check("ovr_drain_pend",  32'(pending), 32'h00);

        // Async reset with three queued and one pending, then req held across release.
        out_ready = 1'b0;
        pulse(8'hF0);
        step(5);
        check("rst_pre_level", 32'(level),   32'd3);
        check("rst_pre_pend",  32'(pending), 32'h10);
        req = 8'h01;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level),     32'd0);
        check("arst_pend",  32'(pending),   32'h00);
        step(2);
        rst = 1'b0;
        step(8);
        check("hold_level",   32'(level),     32'd0);
        check("hold_valid",   32'(out_valid), 32'd0);
        check("hold_pend",    32'(pending),   32'h00);
        check("hold_overrun", 32'(overrun),   32'd0);
        req = 8'd0;
        step(4);
        check("hold_fall", 32'(level), 32'd0);
        pulse(8'h01);
        step(3);
        check("post_valid", 32'(out_valid), 32'd1);
        check("post_code",  32'(out_code),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
